// File: rtl/pcie_us_axil_rq_bridge_pkg.sv
// Shared definitions for the AXI-lite to PCIe requester bridge: descriptor
// field offsets, request/completion codes, AXI response codes and FSM states.
package pcie_us_axil_rq_bridge_pkg;

    localparam int DESC_DWCNT_LSB    = 64;
    localparam int DESC_REQ_TYPE_LSB = 75;
    localparam int DESC_REQ_ID_LSB   = 80;
    localparam int DESC_TAG_LSB      = 96;
    localparam int DESC_ID_EN_BIT    = 120;

    localparam int RC_ERR_LSB    = 12;
    localparam int RC_STATUS_LSB = 43;
    localparam int RC_TAG_LSB    = 64;
    localparam int RC_DATA_LSB   = 96;

    localparam logic [3:0] REQ_MEM_RD = 4'b0000;
    localparam logic [3:0] REQ_MEM_WR = 4'b0001;

    localparam logic [2:0] CPL_STATUS_SC = 3'b000;
    localparam logic [2:0] CPL_STATUS_UR = 3'b001;

    localparam logic [1:0] AXI_RESP_OKAY   = 2'b00;
    localparam logic [1:0] AXI_RESP_SLVERR = 2'b10;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_WR_HDR,
        ST_WR_DATA,
        ST_WR_RESP,
        ST_RD_HDR,
        ST_RD_WAIT,
        ST_RD_RESP
    } state_t;

    // Single-DW memory request descriptor (beat 0 of every RQ TLP).
    function automatic logic [127:0] rq_desc(
        input logic [63:0] addr,
        input logic [3:0]  req_type,
        input logic [15:0] req_id,
        input logic [7:0]  tag,
        input logic        id_en
    );
        logic [127:0] d;
        d = '0;
        d[63:2]                      = addr[63:2];
        d[DESC_DWCNT_LSB +: 11]      = 11'd1;
        d[DESC_REQ_TYPE_LSB +: 4]    = req_type;
        d[DESC_REQ_ID_LSB +: 16]     = req_id;
        d[DESC_TAG_LSB +: 8]         = tag;
        d[DESC_ID_EN_BIT]            = id_en;
        return d;
    endfunction

endpackage

// File: rtl/pcie_us_axil_rq_bridge.sv
// AXI-lite slave to UltraScale PCIe RQ/RC bridge: one single-DW MemWr/MemRd
// outstanding at a time, read completions matched by tag with timeout.
module pcie_us_axil_rq_bridge
    import pcie_us_axil_rq_bridge_pkg::*;
#(
    parameter int AXIS_PCIE_DATA_WIDTH    = 128,
    parameter int AXIS_PCIE_KEEP_WIDTH    = 4,
    parameter int AXIS_PCIE_RQ_USER_WIDTH = 60,
    parameter int AXIS_PCIE_RC_USER_WIDTH = 75,
    parameter int AXIL_ADDR_WIDTH         = 64,
    parameter int TIMEOUT_CYCLES          = 65535
) (
    input  logic                               clk,
    input  logic                               rst_n,
    output logic [AXIS_PCIE_DATA_WIDTH-1:0]    m_axis_rq_tdata,
    output logic [AXIS_PCIE_KEEP_WIDTH-1:0]    m_axis_rq_tkeep,
    output logic                               m_axis_rq_tvalid,
    input  logic                               m_axis_rq_tready,
    output logic                               m_axis_rq_tlast,
    output logic [AXIS_PCIE_RQ_USER_WIDTH-1:0] m_axis_rq_tuser,
    input  logic [AXIS_PCIE_DATA_WIDTH-1:0]    s_axis_rc_tdata,
    input  logic [AXIS_PCIE_KEEP_WIDTH-1:0]    s_axis_rc_tkeep,
    input  logic                               s_axis_rc_tvalid,
    output logic                               s_axis_rc_tready,
    input  logic                               s_axis_rc_tlast,
    input  logic [AXIS_PCIE_RC_USER_WIDTH-1:0] s_axis_rc_tuser,
    input  logic [AXIL_ADDR_WIDTH-1:0]         s_axil_awaddr,
    input  logic [2:0]                         s_axil_awprot,
    input  logic                               s_axil_awvalid,
    output logic                               s_axil_awready,
    input  logic [31:0]                        s_axil_wdata,
    input  logic [3:0]                         s_axil_wstrb,
    input  logic                               s_axil_wvalid,
    output logic                               s_axil_wready,
    output logic [1:0]                         s_axil_bresp,
    output logic                               s_axil_bvalid,
    input  logic                               s_axil_bready,
    input  logic [AXIL_ADDR_WIDTH-1:0]         s_axil_araddr,
    input  logic [2:0]                         s_axil_arprot,
    input  logic                               s_axil_arvalid,
    output logic                               s_axil_arready,
    output logic [31:0]                        s_axil_rdata,
    output logic [1:0]                         s_axil_rresp,
    output logic                               s_axil_rvalid,
    input  logic                               s_axil_rready,
    input  logic [15:0]                        requester_id,
    input  logic                               requester_id_enable,
    output logic                               status_error_cor,
    output logic                               status_error_uncor
);

    localparam int TMO_W = $clog2(TIMEOUT_CYCLES + 1);

    state_t state_reg, state_next;
    logic        prio_wr_reg, prio_wr_next;
    logic [7:0]  tag_reg, tag_next;
    logic [31:0] wdata_reg, wdata_next;
    logic [TMO_W-1:0] tmo_cnt_reg, tmo_cnt_next;
    logic        rc_in_pkt_reg, rc_in_pkt_next;

    logic [AXIS_PCIE_DATA_WIDTH-1:0]    rq_tdata_reg, rq_tdata_next;
    logic [AXIS_PCIE_KEEP_WIDTH-1:0]    rq_tkeep_reg, rq_tkeep_next;
    logic                               rq_tvalid_reg, rq_tvalid_next;
    logic                               rq_tlast_reg, rq_tlast_next;
    logic [AXIS_PCIE_RQ_USER_WIDTH-1:0] rq_tuser_reg, rq_tuser_next;
    logic        rc_tready_reg, rc_tready_next;
    logic        awready_reg, awready_next;
    logic        arready_reg, arready_next;
    logic        bvalid_reg, bvalid_next;
    logic [1:0]  bresp_reg, bresp_next;
    logic        rvalid_reg, rvalid_next;
    logic [1:0]  rresp_reg, rresp_next;
    logic [31:0] rdata_reg, rdata_next;
    logic        err_cor_reg, err_cor_next;
    logic        err_uncor_reg, err_uncor_next;

    logic [63:0] aw_addr64, ar_addr64;
    logic        wr_elig, rd_elig, rc_accept, rc_first, tag_match, cpl_ok;
    logic        unused_inputs;

    assign aw_addr64 = 64'(s_axil_awaddr);
    assign ar_addr64 = 64'(s_axil_araddr);
    assign wr_elig   = s_axil_awvalid && s_axil_wvalid;
    assign rd_elig   = s_axil_arvalid;
    assign rc_accept = s_axis_rc_tvalid && rc_tready_reg;
    assign rc_first  = !rc_in_pkt_reg;
    assign tag_match = s_axis_rc_tdata[RC_TAG_LSB +: 8] == tag_reg;
    assign cpl_ok    = (s_axis_rc_tdata[RC_STATUS_LSB +: 3] == CPL_STATUS_SC) &&
                       (s_axis_rc_tdata[RC_ERR_LSB +: 4] == 4'h0);

    assign unused_inputs = ^{s_axil_awprot, s_axil_arprot, s_axis_rc_tkeep, s_axis_rc_tuser,
                             s_axis_rc_tdata[95:72], s_axis_rc_tdata[63:46],
                             s_axis_rc_tdata[42:16], s_axis_rc_tdata[11:0]};

    always_comb begin
        state_next     = state_reg;
        prio_wr_next   = prio_wr_reg;
        tag_next       = tag_reg;
        wdata_next     = wdata_reg;
        tmo_cnt_next   = tmo_cnt_reg;
        rq_tdata_next  = rq_tdata_reg;
        rq_tkeep_next  = rq_tkeep_reg;
        rq_tvalid_next = rq_tvalid_reg;
        rq_tlast_next  = rq_tlast_reg;
        rq_tuser_next  = rq_tuser_reg;
        awready_next   = 1'b0;
        arready_next   = 1'b0;
        bvalid_next    = bvalid_reg;
        bresp_next     = bresp_reg;
        rvalid_next    = rvalid_reg;
        rresp_next     = rresp_reg;
        rdata_next     = rdata_reg;
        err_uncor_next = 1'b0;
        // Only the first beat of a completion carries the tag; later beats follow it.
        err_cor_next   = rc_accept && rc_first && !(state_reg == ST_RD_WAIT && tag_match);
        rc_in_pkt_next = rc_accept ? !s_axis_rc_tlast : rc_in_pkt_reg;

        case (state_reg)
            ST_IDLE: begin
                if (wr_elig && (prio_wr_reg || !rd_elig)) begin
                    awready_next   = 1'b1;
                    prio_wr_next   = !prio_wr_reg;
                    wdata_next     = s_axil_wdata;
                    rq_tdata_next  = rq_desc(aw_addr64, REQ_MEM_WR, requester_id, tag_reg,
                                             requester_id_enable);
                    rq_tkeep_next  = '1;
                    rq_tlast_next  = 1'b0;
                    rq_tvalid_next = 1'b1;
                    rq_tuser_next  = '0;
                    rq_tuser_next[3:0]  = s_axil_wstrb;
                    rq_tuser_next[10:8] = aw_addr64[4:2];
                    state_next     = ST_WR_HDR;
                end else if (rd_elig) begin
                    arready_next   = 1'b1;
                    prio_wr_next   = !prio_wr_reg;
                    rq_tdata_next  = rq_desc(ar_addr64, REQ_MEM_RD, requester_id, tag_reg,
                                             requester_id_enable);
                    rq_tkeep_next  = '1;
                    rq_tlast_next  = 1'b1;
                    rq_tvalid_next = 1'b1;
                    rq_tuser_next  = '0;
                    rq_tuser_next[3:0]  = 4'hF;
                    rq_tuser_next[10:8] = ar_addr64[4:2];
                    state_next     = ST_RD_HDR;
                end
            end
            ST_WR_HDR: begin
                if (m_axis_rq_tready) begin
                    rq_tdata_next       = '0;
                    rq_tdata_next[31:0] = wdata_reg;
                    rq_tkeep_next       = AXIS_PCIE_KEEP_WIDTH'(1);
                    rq_tlast_next       = 1'b1;
                    state_next          = ST_WR_DATA;
                end
            end
            ST_WR_DATA: begin
                if (m_axis_rq_tready) begin
                    rq_tvalid_next = 1'b0;
                    bvalid_next    = 1'b1;
                    bresp_next     = AXI_RESP_OKAY;
                    state_next     = ST_WR_RESP;
                end
            end
            ST_WR_RESP: begin
                if (s_axil_bready) begin
                    bvalid_next = 1'b0;
                    state_next  = ST_IDLE;
                end
            end
            ST_RD_HDR: begin
                if (m_axis_rq_tready) begin
                    rq_tvalid_next = 1'b0;
                    tmo_cnt_next   = '0;
                    state_next     = ST_RD_WAIT;
                end
            end
            ST_RD_WAIT: begin
                if (rc_accept && rc_first && tag_match) begin
                    rvalid_next = 1'b1;
                    rresp_next  = cpl_ok ? AXI_RESP_OKAY : AXI_RESP_SLVERR;
                    rdata_next  = cpl_ok ? s_axis_rc_tdata[RC_DATA_LSB +: 32] : 32'h0;
                    tag_next    = tag_reg + 8'd1;
                    state_next  = ST_RD_RESP;
                end else if (tmo_cnt_reg == TMO_W'(TIMEOUT_CYCLES - 1)) begin
                    rvalid_next    = 1'b1;
                    rresp_next     = AXI_RESP_SLVERR;
                    rdata_next     = 32'hFFFF_FFFF;
                    err_uncor_next = 1'b1;
                    tag_next       = tag_reg + 8'd1;
                    state_next     = ST_RD_RESP;
                end else begin
                    tmo_cnt_next = tmo_cnt_reg + TMO_W'(1);
                end
            end
            ST_RD_RESP: begin
                if (s_axil_rready) begin
                    rvalid_next = 1'b0;
                    state_next  = ST_IDLE;
                end
            end
            default: state_next = ST_IDLE;
        endcase

        rc_tready_next = (state_next != ST_RD_RESP);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg     <= ST_IDLE;
            prio_wr_reg   <= 1'b1;
            tag_reg       <= '0;
            wdata_reg     <= '0;
            tmo_cnt_reg   <= '0;
            rc_in_pkt_reg <= 1'b0;
            rq_tdata_reg  <= '0;
            rq_tkeep_reg  <= '0;
            rq_tvalid_reg <= 1'b0;
            rq_tlast_reg  <= 1'b0;
            rq_tuser_reg  <= '0;
            rc_tready_reg <= 1'b0;
            awready_reg   <= 1'b0;
            arready_reg   <= 1'b0;
            bvalid_reg    <= 1'b0;
            bresp_reg     <= '0;
            rvalid_reg    <= 1'b0;
            rresp_reg     <= '0;
            rdata_reg     <= '0;
            err_cor_reg   <= 1'b0;
            err_uncor_reg <= 1'b0;
        end else begin
            state_reg     <= state_next;
            prio_wr_reg   <= prio_wr_next;
            tag_reg       <= tag_next;
            wdata_reg     <= wdata_next;
            tmo_cnt_reg   <= tmo_cnt_next;
            rc_in_pkt_reg <= rc_in_pkt_next;
            rq_tdata_reg  <= rq_tdata_next;
            rq_tkeep_reg  <= rq_tkeep_next;
            rq_tvalid_reg <= rq_tvalid_next;
            rq_tlast_reg  <= rq_tlast_next;
            rq_tuser_reg  <= rq_tuser_next;
            rc_tready_reg <= rc_tready_next;
            awready_reg   <= awready_next;
            arready_reg   <= arready_next;
            bvalid_reg    <= bvalid_next;
            bresp_reg     <= bresp_next;
            rvalid_reg    <= rvalid_next;
            rresp_reg     <= rresp_next;
            rdata_reg     <= rdata_next;
            err_cor_reg   <= err_cor_next;
            err_uncor_reg <= err_uncor_next;
        end
    end

    assign m_axis_rq_tdata    = rq_tdata_reg;
    assign m_axis_rq_tkeep    = rq_tkeep_reg;
    assign m_axis_rq_tvalid   = rq_tvalid_reg;
    assign m_axis_rq_tlast    = rq_tlast_reg;
    assign m_axis_rq_tuser    = rq_tuser_reg;
    assign s_axis_rc_tready   = rc_tready_reg;
    assign s_axil_awready     = awready_reg;
    assign s_axil_wready      = awready_reg;
    assign s_axil_arready     = arready_reg;
    assign s_axil_bvalid      = bvalid_reg;
    assign s_axil_bresp       = bresp_reg;
    assign s_axil_rvalid      = rvalid_reg;
    assign s_axil_rresp       = rresp_reg;
    assign s_axil_rdata       = rdata_reg;
    assign status_error_cor   = err_cor_reg;
    assign status_error_uncor = err_uncor_reg;

endmodule

// File: tb/tb_pcie_us_axil_rq_bridge.sv
// Bench for pcie_us_axil_rq_bridge: directed cases plus random single-DW
// reads/writes against a field-level model of the expected TLPs and responses.
module tb_pcie_us_axil_rq_bridge;

    localparam int TMO = 100;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    logic [127:0] m_axis_rq_tdata;
    logic [3:0]   m_axis_rq_tkeep;
    logic         m_axis_rq_tvalid;
    logic         m_axis_rq_tready = 1'b0;
    logic         m_axis_rq_tlast;
    logic [59:0]  m_axis_rq_tuser;
    logic [127:0] s_axis_rc_tdata = '0;
    logic [3:0]   s_axis_rc_tkeep = '0;
    logic         s_axis_rc_tvalid = 1'b0;
    logic         s_axis_rc_tready;
    logic         s_axis_rc_tlast = 1'b0;
    logic [74:0]  s_axis_rc_tuser = '0;
    logic [63:0]  s_axil_awaddr = '0;
    logic [2:0]   s_axil_awprot = '0;
    logic         s_axil_awvalid = 1'b0;
    logic         s_axil_awready;
    logic [31:0]  s_axil_wdata = '0;
    logic [3:0]   s_axil_wstrb = '0;
    logic         s_axil_wvalid = 1'b0;
    logic         s_axil_wready;
    logic [1:0]   s_axil_bresp;
    logic         s_axil_bvalid;
    logic         s_axil_bready = 1'b0;
    logic [63:0]  s_axil_araddr = '0;
    logic [2:0]   s_axil_arprot = '0;
    logic         s_axil_arvalid = 1'b0;
    logic         s_axil_arready;
    logic [31:0]  s_axil_rdata;
    logic [1:0]   s_axil_rresp;
    logic         s_axil_rvalid;
    logic         s_axil_rready = 1'b0;
    logic [15:0]  requester_id = 16'hABCD;
    logic         requester_id_enable = 1'b1;
    logic         status_error_cor;
    logic         status_error_uncor;

    pcie_us_axil_rq_bridge #(.TIMEOUT_CYCLES(TMO)) dut (
        .clk(clk), .rst_n(rst_n),
        .m_axis_rq_tdata(m_axis_rq_tdata), .m_axis_rq_tkeep(m_axis_rq_tkeep),
        .m_axis_rq_tvalid(m_axis_rq_tvalid), .m_axis_rq_tready(m_axis_rq_tready),
        .m_axis_rq_tlast(m_axis_rq_tlast), .m_axis_rq_tuser(m_axis_rq_tuser),
        .s_axis_rc_tdata(s_axis_rc_tdata), .s_axis_rc_tkeep(s_axis_rc_tkeep),
        .s_axis_rc_tvalid(s_axis_rc_tvalid), .s_axis_rc_tready(s_axis_rc_tready),
        .s_axis_rc_tlast(s_axis_rc_tlast), .s_axis_rc_tuser(s_axis_rc_tuser),
        .s_axil_awaddr(s_axil_awaddr), .s_axil_awprot(s_axil_awprot),
        .s_axil_awvalid(s_axil_awvalid), .s_axil_awready(s_axil_awready),
        .s_axil_wdata(s_axil_wdata), .s_axil_wstrb(s_axil_wstrb),
        .s_axil_wvalid(s_axil_wvalid), .s_axil_wready(s_axil_wready),
        .s_axil_bresp(s_axil_bresp), .s_axil_bvalid(s_axil_bvalid), .s_axil_bready(s_axil_bready),
        .s_axil_araddr(s_axil_araddr), .s_axil_arprot(s_axil_arprot),
        .s_axil_arvalid(s_axil_arvalid), .s_axil_arready(s_axil_arready),
        .s_axil_rdata(s_axil_rdata), .s_axil_rresp(s_axil_rresp),
        .s_axil_rvalid(s_axil_rvalid), .s_axil_rready(s_axil_rready),
        .requester_id(requester_id), .requester_id_enable(requester_id_enable),
        .status_error_cor(status_error_cor), .status_error_uncor(status_error_uncor)
    );

    int checks = 0;
    int failures = 0;
    logic [7:0]   exp_tag = 8'd0;
    logic [127:0] cap_data;
    logic [3:0]   cap_keep;
    logic         cap_last;
    logic [59:0]  cap_user;
    logic         got_aw, got_ar;

    task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [127:0] exp_desc(input logic [63:0] a, input logic [3:0] typ);
        return {7'b0, requester_id_enable, 16'b0, exp_tag, requester_id, 1'b0, typ, 11'd1,
                a[63:2], 2'b00};
    endfunction

    function automatic logic [59:0] exp_user(input logic [63:0] a, input logic [3:0] be);
        return {49'b0, a[4:2], 4'b0000, be};
    endfunction

    task automatic get_rq();
        logic ok, stalled;
        logic [127:0] held;
        ok = 1'b0;
        stalled = 1'b0;
        held = '0;
        for (int i = 0; i < 200; i++) begin
            @(negedge clk);
            if (stalled) check("rq_hold", {m_axis_rq_tvalid, m_axis_rq_tdata}, {1'b1, held});
            m_axis_rq_tready = 1'($urandom_range(0, 1));
            if (m_axis_rq_tvalid && m_axis_rq_tready) begin
                cap_data = m_axis_rq_tdata;
                cap_keep = m_axis_rq_tkeep;
                cap_last = m_axis_rq_tlast;
                cap_user = m_axis_rq_tuser;
                ok = 1'b1;
                break;
            end
            stalled = m_axis_rq_tvalid;
            held = m_axis_rq_tdata;
        end
        check("rq_beat_seen", ok, 1'b1);
    endtask

    task automatic wait_grant();
        logic ok;
        ok = 1'b0;
        for (int i = 0; i < 50; i++) begin
            @(negedge clk);
            if (s_axil_awready || s_axil_arready) begin
                ok = 1'b1;
                break;
            end
        end
        got_aw = s_axil_awready;
        got_ar = s_axil_arready;
        check("grant_seen", ok, 1'b1);
        check("wready_eq_awready", s_axil_wready, s_axil_awready);
    endtask

    task automatic start_write(input logic [63:0] a, input logic [31:0] d, input logic [3:0] s);
        m_axis_rq_tready = 1'b0;
        @(negedge clk);
        s_axil_awaddr = a; s_axil_wdata = d; s_axil_wstrb = s;
        s_axil_awvalid = 1'b1; s_axil_wvalid = 1'b1;
    endtask

    task automatic start_read(input logic [63:0] a);
        m_axis_rq_tready = 1'b0;
        @(negedge clk);
        s_axil_araddr = a;
        s_axil_arvalid = 1'b1;
    endtask

    task automatic finish_write(input logic [63:0] a, input logic [31:0] d, input logic [3:0] s);
        logic ok;
        @(posedge clk);
        #1 s_axil_awvalid = 1'b0; s_axil_wvalid = 1'b0;
        @(negedge clk);
        check("aw_w_ready_pulse", {s_axil_awready, s_axil_wready}, 2'b00);
        get_rq();
        check("wr_desc", cap_data, exp_desc(a, 4'b0001));
        check("wr_hdr_keep_last", {cap_keep, cap_last}, {4'hF, 1'b0});
        check("wr_user", cap_user, exp_user(a, s));
        get_rq();
        check("wr_data", cap_data[31:0], d);
        check("wr_data_keep_last", {cap_keep, cap_last}, {4'h1, 1'b1});
        ok = 1'b0;
        for (int i = 0; i < 50; i++) begin
            @(negedge clk);
            if (s_axil_bvalid) begin ok = 1'b1; break; end
        end
        check("b_seen", ok, 1'b1);
        check("bresp", s_axil_bresp, 2'b00);
        repeat ($urandom_range(0, 2)) begin
            @(negedge clk);
            check("b_hold", s_axil_bvalid, 1'b1);
        end
        s_axil_bready = 1'b1;
        @(posedge clk);
        #1 s_axil_bready = 1'b0;
        @(negedge clk);
        check("b_done", s_axil_bvalid, 1'b0);
        $display("WRITE addr=%h data=%h strb=%h tag=%0d", a, d, s, exp_tag);
    endtask

    task automatic send_rc(input logic [7:0] tag, input logic [2:0] st, input logic [3:0] ec,
                           input logic [31:0] d);
        logic [127:0] t;
        logic ok;
        t = {$urandom, $urandom, $urandom, $urandom};
        t[127:96] = d; t[71:64] = tag; t[45:43] = st; t[15:12] = ec;
        @(negedge clk);
        s_axis_rc_tdata = t; s_axis_rc_tkeep = 4'hF; s_axis_rc_tlast = 1'b1;
        s_axis_rc_tuser = 75'({$urandom, $urandom, $urandom});
        s_axis_rc_tvalid = 1'b1;
        ok = 1'b0;
        for (int i = 0; i < 50; i++) begin
            if (s_axis_rc_tready) begin ok = 1'b1; break; end
            @(negedge clk);
        end
        @(posedge clk);
        #1 s_axis_rc_tvalid = 1'b0;
        check("rc_accepted", ok, 1'b1);
    endtask

    task automatic expect_cor_pulse(input string tag);
        @(negedge clk);
        check({tag, "_cor_hi"}, status_error_cor, 1'b1);
        @(negedge clk);
        check({tag, "_cor_lo"}, status_error_cor, 1'b0);
    endtask

    // mode 0: matching completion; 1: stray tag first; 2: no completion (timeout)
    task automatic finish_read(input logic [63:0] a, input int mode, input logic [2:0] st,
                               input logic [3:0] ec, input logic [31:0] d);
        logic ok, unc_at_rv;
        int n;
        logic [31:0] e_data;
        logic [1:0] e_resp;
        @(posedge clk);
        #1 s_axil_arvalid = 1'b0;
        @(negedge clk);
        check("arready_pulse", s_axil_arready, 1'b0);
        get_rq();
        check("rd_desc", cap_data, exp_desc(a, 4'b0000));
        check("rd_keep_last", {cap_keep, cap_last}, {4'hF, 1'b1});
        check("rd_user", cap_user, exp_user(a, 4'hF));
        ok = 1'b0;
        n = 0;
        unc_at_rv = 1'b0;
        if (mode == 2) begin
            for (n = 1; n <= TMO + 20; n++) begin
                @(negedge clk);
                if (s_axil_rvalid) begin ok = 1'b1; unc_at_rv = status_error_uncor; break; end
                check("uncor_early", status_error_uncor, 1'b0);
            end
            check("tmo_rvalid", ok, 1'b1);
            check("tmo_uncor_pulse", unc_at_rv, 1'b1);
            check("tmo_latency_ok", (n >= TMO && n <= TMO + 2), 1'b1);
            e_data = 32'hFFFF_FFFF;
            e_resp = 2'b10;
        end else begin
            if (mode == 1) begin
                send_rc(exp_tag ^ 8'h55, 3'b000, 4'h0, $urandom);
                expect_cor_pulse("stray_tag");
                check("stray_no_rvalid", s_axil_rvalid, 1'b0);
            end
            send_rc(exp_tag, st, ec, d);
            for (int i = 0; i < 20; i++) begin
                @(negedge clk);
                if (i == 0) check("match_no_cor", status_error_cor, 1'b0);
                if (s_axil_rvalid) begin ok = 1'b1; break; end
            end
            check("r_seen", ok, 1'b1);
            e_resp = (st == 3'b000 && ec == 4'h0) ? 2'b00 : 2'b10;
            e_data = (e_resp == 2'b00) ? d : 32'h0;
        end
        check("rdata", s_axil_rdata, e_data);
        check("rresp", s_axil_rresp, e_resp);
        check("rc_tready_low_in_resp", s_axis_rc_tready, 1'b0);
        repeat ($urandom_range(0, 2)) begin
            @(negedge clk);
            check("r_hold", {s_axil_rvalid, s_axil_rdata}, {1'b1, e_data});
        end
        s_axil_rready = 1'b1;
        @(posedge clk);
        #1 s_axil_rready = 1'b0;
        @(negedge clk);
        check("r_done", s_axil_rvalid, 1'b0);
        $display("READ  addr=%h tag=%0d mode=%0d rdata=%h rresp=%0d", a, exp_tag, mode,
                 s_axil_rdata, s_axil_rresp);
        exp_tag = exp_tag + 8'd1;
    endtask

    task automatic do_write(input logic [63:0] a, input logic [31:0] d, input logic [3:0] s);
        start_write(a, d, s);
        wait_grant();
        check("wr_grant_kind", {got_aw, got_ar}, 2'b10);
        finish_write(a, d, s);
    endtask

    task automatic do_read(input logic [63:0] a, input int mode, input logic [2:0] st,
                           input logic [3:0] ec, input logic [31:0] d);
        start_read(a);
        wait_grant();
        check("rd_grant_kind", {got_aw, got_ar}, 2'b01);
        finish_read(a, mode, st, ec, d);
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_ctl"}, {m_axis_rq_tvalid, m_axis_rq_tlast, m_axis_rq_tkeep, m_axis_rq_tuser,
                              s_axis_rc_tready, s_axil_awready, s_axil_wready, s_axil_arready,
                              s_axil_bvalid, s_axil_bresp, s_axil_rvalid, s_axil_rresp,
                              s_axil_rdata, status_error_cor, status_error_uncor}, '0);
        check({tag, "_tdata"}, m_axis_rq_tdata, '0);
    endtask

    initial begin
        logic [63:0] a;
        logic [2:0]  st;
        logic [3:0]  ec;
        logic [7:0]  old_tag;

        repeat (3) @(negedge clk);
        check_reset_outputs("reset");
        rst_n = 1'b1;
        @(negedge clk);

        do_write(64'h0000_0001_2345_6788, 32'hDEADBEEF, 4'hF);
        do_read(64'h1000, 0, 3'b000, 4'h0, 32'h12345678);
        requester_id_enable = 1'b0;
        requester_id = 16'h0102;
        do_read(64'h2004, 0, 3'b001, 4'h0, 32'hCAFEF00D);
        do_write(64'h0000_0000_0000_3010, 32'h0BADF00D, 4'h0);
        do_read(64'h3008, 1, 3'b000, 4'h0, 32'h87654321);
        old_tag = exp_tag;
        do_read(64'h4000_0000_0000_001C, 2, 3'b000, 4'h0, 32'h0);
        send_rc(old_tag, 3'b000, 4'h0, 32'h11111111);
        expect_cor_pulse("late_cpl");

        for (int k = 0; k < 30; k++) begin
            requester_id = 16'($urandom);
            requester_id_enable = 1'($urandom_range(0, 1));
            a = {$urandom, $urandom};
            if ($urandom_range(0, 1) == 0) begin
                do_write(a, $urandom, 4'($urandom));
            end else begin
                st = ($urandom_range(0, 3) == 0) ? 3'($urandom) : 3'b000;
                ec = ($urandom_range(0, 3) == 0) ? 4'($urandom) : 4'h0;
                do_read(a, $urandom_range(0, 1), st, ec, $urandom);
            end
        end

        // Reset while the write data beat is pending.
        start_write(64'h5550, 32'h55AA55AA, 4'h3);
        wait_grant();
        check("rst_wr_grant", got_aw, 1'b1);
        @(posedge clk);
        #1 s_axil_awvalid = 1'b0; s_axil_wvalid = 1'b0;
        get_rq();
        @(posedge clk);
        #1 m_axis_rq_tready = 1'b0;
        #2 check("in_wr_data", {m_axis_rq_tvalid, m_axis_rq_tlast}, 2'b11);
        rst_n = 1'b0;
        #1 check_reset_outputs("async_reset");
        repeat (3) @(negedge clk);
        check_reset_outputs("reset_held");
        $display("RESET mid-write, outputs cleared");
        rst_n = 1'b1;
        exp_tag = 8'd0;

        // Simultaneous write and read after reset: write wins, read follows.
        m_axis_rq_tready = 1'b0;
        @(negedge clk);
        s_axil_awaddr = 64'h6000; s_axil_wdata = 32'h01234567; s_axil_wstrb = 4'hC;
        s_axil_araddr = 64'h7004;
        s_axil_awvalid = 1'b1; s_axil_wvalid = 1'b1; s_axil_arvalid = 1'b1;
        wait_grant();
        check("simul_first", {got_aw, got_ar}, 2'b10);
        finish_write(64'h6000, 32'h01234567, 4'hC);
        m_axis_rq_tready = 1'b0;
        wait_grant();
        check("simul_second", {got_aw, got_ar}, 2'b01);
        finish_read(64'h7004, 0, 3'b000, 4'h0, 32'hA5A5A5A5);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #5000000;
        $display("FAIL global_timeout observed=running expected=finished");
        $fatal(1, "simulation time limit");
    end

endmodule
